// File: rtl/wb_dma_copy.sv
// rtl/wb_dma_copy.sv - Wishbone word-copy DMA engine; WB_DMA_TIMEOUT_EN adds an mbus ack watchdog
module wb_dma_copy #(
   parameter int CNT_W = 16,
   parameter int TIMEOUT = 1024
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              bus_cyc,
   input  logic              bus_stb,
   input  logic              bus_we,
   input  logic [31:0]       bus_adr,
   input  logic [3:0]        bus_sel,
   input  logic [31:0]       bus_dat_m,
   output logic [31:0]       bus_dat_s,
   output logic              bus_ack,
   output logic              mbus_cyc,
   output logic              mbus_stb,
   output logic              mbus_we,
   output logic [31:0]       mbus_adr,
   output logic [3:0]        mbus_sel,
   output logic [31:0]       mbus_dat_m,
   input  logic [31:0]       mbus_dat_s,
   input  logic              mbus_ack,
   output logic              interrupt
);

   typedef enum logic [2:0] {S_IDLE, S_RD, S_RD_GAP, S_WR, S_WR_GAP} state_t;

   state_t           state, state_d;
   logic [31:0]      src, dst, buffer;
   logic [CNT_W-1:0] count;
   logic             ie, done, err;
   logic             held;
   logic             accept, wr_en, busy, start_req;
   logic [1:0]       reg_sel;
   logic             buf_ld, adv, done_set, err_set;
   logic             unused_bus;

   assign unused_bus = &{1'b0, bus_sel, bus_adr[31:4], bus_adr[1:0]};

   // held blocks a second ack while the master keeps one transaction open
   assign accept    = bus_cyc & bus_stb & ~bus_ack & ~held;
   assign wr_en     = accept & bus_we;
   assign reg_sel   = bus_adr[3:2];
   assign busy      = (state != S_IDLE);
   assign start_req = wr_en & (reg_sel == 2'd3) & bus_dat_m[0] & ~busy;
   assign interrupt = (done | err) & ie;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         bus_ack <= 1'b0;
         held    <= 1'b0;
      end else begin
         bus_ack <= accept;
         held    <= bus_cyc & bus_stb & (bus_ack | held);
      end
   end

   always_comb begin
      bus_dat_s = '0;
      if (bus_ack) begin
         case (reg_sel)
            2'd0:    bus_dat_s = src;
            2'd1:    bus_dat_s = dst;
            2'd2:    bus_dat_s = 32'(count);
            default: bus_dat_s = {27'd0, err, ie, done, busy, 1'b0};
         endcase
      end
   end

   assign mbus_cyc   = (state == S_RD) | (state == S_WR);
   assign mbus_stb   = mbus_cyc;
   assign mbus_we    = (state == S_WR);
   assign mbus_sel   = mbus_cyc ? 4'hf : 4'h0;
   assign mbus_adr   = (state == S_RD) ? src : (state == S_WR) ? dst : 32'd0;
   assign mbus_dat_m = (state == S_WR) ? buffer : 32'd0;

`ifdef WB_DMA_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);
   logic [WD_W-1:0] wd_cnt;
   logic            waiting, wd_expire;

   assign waiting   = mbus_cyc & mbus_stb & ~mbus_ack;
   assign wd_expire = waiting & (wd_cnt == WD_W'(TIMEOUT - 1));

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)       wd_cnt <= '0;
      else if (waiting) wd_cnt <= wd_cnt + WD_W'(1);
      else              wd_cnt <= '0;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)                                        err <= 1'b0;
      else if (err_set)                                  err <= 1'b1;
      else if (wr_en && reg_sel == 2'd3 && bus_dat_m[4]) err <= 1'b0;
   end
`else
   assign err = 1'b0;
`endif

   always_comb begin
      state_d  = state;
      buf_ld   = 1'b0;
      adv      = 1'b0;
      done_set = 1'b0;
      err_set  = 1'b0;
      case (state)
         S_IDLE: if (start_req) begin
            if (count != '0) state_d = S_RD;
            else             done_set = 1'b1;
         end
         S_RD: if (mbus_ack) begin
            buf_ld  = 1'b1;
            state_d = S_RD_GAP;
         end
         S_RD_GAP: state_d = S_WR;
         S_WR: if (mbus_ack) begin
            adv     = 1'b1;
            state_d = S_WR_GAP;
         end
         S_WR_GAP: begin
            if (count == '0) begin
               state_d  = S_IDLE;
               done_set = 1'b1;
            end else begin
               state_d = S_RD;
            end
         end
         default: state_d = S_IDLE;
      endcase
`ifdef WB_DMA_TIMEOUT_EN
      // the failing word leaves SRC/DST/COUNT untouched so software can retry it
      if (wd_expire) begin
         state_d = S_IDLE;
         buf_ld  = 1'b0;
         adv     = 1'b0;
         err_set = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state  <= S_IDLE;
         src    <= '0;
         dst    <= '0;
         count  <= '0;
         buffer <= '0;
         ie     <= 1'b0;
         done   <= 1'b0;
      end else begin
         state <= state_d;
         if (buf_ld) buffer <= mbus_dat_s;
         // register writes only land while idle, so they never race the advance
         if (wr_en && reg_sel == 2'd0 && !busy)      src <= {bus_dat_m[31:2], 2'b00};
         else if (adv)                               src <= src + 32'd4;
         if (wr_en && reg_sel == 2'd1 && !busy)      dst <= {bus_dat_m[31:2], 2'b00};
         else if (adv)                               dst <= dst + 32'd4;
         if (wr_en && reg_sel == 2'd2 && !busy)      count <= bus_dat_m[CNT_W-1:0];
         else if (adv)                               count <= count - CNT_W'(1);
         if (wr_en && reg_sel == 2'd3)               ie <= bus_dat_m[3];
         if (done_set)                               done <= 1'b1;
         else if (wr_en && reg_sel == 2'd3 && bus_dat_m[2]) done <= 1'b0;
      end
   end

endmodule

// File: tb/tb_wb_dma_copy.sv
// tb/tb_wb_dma_copy.sv - directed bench for wb_dma_copy; WB_DMA_TIMEOUT_EN enables the watchdog scenario
module tb_wb_dma_copy;
   logic        clk = 1'b0;
   logic        rst_i;
   logic        bus_cyc, bus_stb, bus_we, bus_ack;
   logic [31:0] bus_adr, bus_dat_m, bus_dat_s;
   logic [3:0]  bus_sel;
   logic        mbus_cyc, mbus_stb, mbus_we, mbus_ack;
   logic [31:0] mbus_adr, mbus_dat_m, mbus_dat_s;
   logic [3:0]  mbus_sel;
   logic        interrupt;

   int checks = 0;
   int failures = 0;

   logic [31:0] mem [logic [31:0]];
   int          wait_states = 0;
   bit          no_ack = 1'b0;
   bit          op_we_q [$];
   logic [31:0] op_adr_q [$];
   logic [31:0] op_dat_q [$];
   int          hi_q [$];
   int          lo_q [$];
   int          hi_run = 0, lo_run = 0, ack_count = 0, wait_cnt = 0;

   always #5 clk = ~clk;

   wb_dma_copy #(.CNT_W(16), .TIMEOUT(16)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .bus_cyc(bus_cyc), .bus_stb(bus_stb), .bus_we(bus_we), .bus_adr(bus_adr),
      .bus_sel(bus_sel), .bus_dat_m(bus_dat_m), .bus_dat_s(bus_dat_s), .bus_ack(bus_ack),
      .mbus_cyc(mbus_cyc), .mbus_stb(mbus_stb), .mbus_we(mbus_we), .mbus_adr(mbus_adr),
      .mbus_sel(mbus_sel), .mbus_dat_m(mbus_dat_m), .mbus_dat_s(mbus_dat_s), .mbus_ack(mbus_ack),
      .interrupt(interrupt)
   );

   // mbus memory slave with programmable wait states plus cyc run-length monitor
   initial begin
      mbus_ack = 1'b0;
      mbus_dat_s = '0;
      forever begin
         @(posedge clk); #1;
         mbus_ack = 1'b0;
         if (mbus_cyc) begin
            if (lo_run > 0) lo_q.push_back(lo_run);
            lo_run = 0;
            hi_run++;
         end else begin
            if (hi_run > 0) hi_q.push_back(hi_run);
            hi_run = 0;
            lo_run++;
            wait_cnt = 0;
         end
         if (mbus_cyc && mbus_stb && !no_ack) begin
            if (wait_cnt < wait_states) begin
               wait_cnt++;
            end else begin
               wait_cnt = 0;
               mbus_ack = 1'b1;
               ack_count++;
               op_we_q.push_back(mbus_we);
               op_adr_q.push_back(mbus_adr);
               if (mbus_we) begin
                  mem[mbus_adr] = mbus_dat_m;
                  op_dat_q.push_back(mbus_dat_m);
               end else begin
                  mbus_dat_s = mem.exists(mbus_adr) ? mem[mbus_adr] : ~mbus_adr;
                  op_dat_q.push_back(mbus_dat_s);
               end
            end
         end
      end
   end

   task automatic clear_log();
      op_we_q.delete(); op_adr_q.delete(); op_dat_q.delete();
      hi_q.delete(); lo_q.delete(); ack_count = 0;
   endtask

   task automatic bus_xfer(input bit we, input logic [31:0] adr, input logic [31:0] wdat,
                           output logic [31:0] rdat);
      int n;
      rdat = '0;
      bus_cyc = 1'b1; bus_stb = 1'b1; bus_we = we; bus_adr = adr; bus_dat_m = wdat; bus_sel = 4'hf;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!bus_ack && n < 8);
      if (!bus_ack) begin
         checks++; failures++;
         $display("FAIL bus_ack_timeout adr=%h got ack=0 want ack=1", adr);
      end else begin
         rdat = bus_dat_s;
      end
      bus_cyc = 1'b0; bus_stb = 1'b0; bus_we = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic reg_wr(input logic [31:0] adr, input logic [31:0] dat);
      logic [31:0] d;
      bus_xfer(1'b1, adr, dat, d);
   endtask

   task automatic reg_rd(input logic [31:0] adr, output logic [31:0] dat);
      bus_xfer(1'b0, adr, 32'd0, dat);
   endtask

   task automatic wait_done(input string name);
      logic [31:0] v;
      int n = 0;
      do begin reg_rd(32'hc, v); n++; end while (v[1] && n < 300);
      if (v[1]) begin
         checks++; failures++;
         $display("FAIL %s_busy_timeout got CTRL=%h want BUSY=0", name, v);
      end
   endtask

   task automatic test_reset();
      logic [31:0] v;
      checks++; if (mbus_cyc !== 1'b0 || mbus_stb !== 1'b0 || mbus_we !== 1'b0) begin failures++; $display("FAIL reset_mbus_ctl got cyc=%b stb=%b we=%b want 0", mbus_cyc, mbus_stb, mbus_we); end
      checks++; if (mbus_adr !== 32'd0 || mbus_dat_m !== 32'd0 || mbus_sel !== 4'd0) begin failures++; $display("FAIL reset_mbus_data got adr=%h dat=%h sel=%h want 0", mbus_adr, mbus_dat_m, mbus_sel); end
      checks++; if (bus_ack !== 1'b0 || interrupt !== 1'b0) begin failures++; $display("FAIL reset_ack_irq got ack=%b irq=%b want 0", bus_ack, interrupt); end
      for (int r = 0; r < 4; r++) begin
         reg_rd(32'(r * 4), v);
         checks++; if (v !== 32'd0) begin failures++; $display("FAIL reset_reg%0d got %h want 0", r, v); end
      end
   endtask

   task automatic test_regs();
      logic [31:0] v;
      reg_wr(32'h0, 32'h0000_0103); reg_rd(32'h0, v);
      checks++; if (v !== 32'h0000_0100) begin failures++; $display("FAIL src_low_bits got %h want %h", v, 32'h100); end
      reg_wr(32'h4, 32'h0000_0fff); reg_rd(32'h4, v);
      checks++; if (v !== 32'h0000_0ffc) begin failures++; $display("FAIL dst_low_bits got %h want %h", v, 32'hffc); end
      reg_wr(32'h8, 32'h0001_2345); reg_rd(32'h8, v);
      checks++; if (v !== 32'h0000_2345) begin failures++; $display("FAIL count_width got %h want %h", v, 32'h2345); end
      reg_wr(32'hc, 32'h0000_0008); reg_rd(32'hc, v);
      checks++; if (v !== 32'h0000_0008 || interrupt !== 1'b0) begin failures++; $display("FAIL ctrl_ie got %h irq=%b want 00000008 irq=0", v, interrupt); end
      reg_wr(32'hc, 32'h0);
   endtask

   task automatic test_ack_hold();
      int acks = 0;
      bus_cyc = 1'b1; bus_stb = 1'b1; bus_we = 1'b0; bus_adr = 32'h0; bus_sel = 4'hf;
      repeat (5) begin @(posedge clk); #1; if (bus_ack) acks++; end
      bus_cyc = 1'b0; bus_stb = 1'b0;
      @(posedge clk); #1;
      checks++; if (acks != 1) begin failures++; $display("FAIL ack_single_pulse got %0d acks want 1", acks); end
   endtask

   task automatic test_copy4();
      logic [31:0] v;
      for (int i = 0; i < 4; i++) mem[32'h100 + 32'(i * 4)] = 32'hc0de_0000 + 32'(i);
      wait_states = 0; clear_log();
      reg_wr(32'h0, 32'h100); reg_wr(32'h4, 32'h2000); reg_wr(32'h8, 32'd4); reg_wr(32'hc, 32'h1);
      wait_done("copy4");
      checks++; if (op_we_q.size() != 8) begin failures++; $display("FAIL copy4_ops got %0d want 8", op_we_q.size()); end
      if (op_we_q.size() == 8) begin
         for (int i = 0; i < 4; i++) begin
            checks++; if (op_we_q[2*i] !== 1'b0 || op_adr_q[2*i] !== 32'h100 + 32'(i * 4)) begin failures++; $display("FAIL copy4_rd%0d got we=%b adr=%h want we=0 adr=%h", i, op_we_q[2*i], op_adr_q[2*i], 32'h100 + 32'(i * 4)); end
            checks++; if (op_we_q[2*i+1] !== 1'b1 || op_adr_q[2*i+1] !== 32'h2000 + 32'(i * 4) || op_dat_q[2*i+1] !== 32'hc0de_0000 + 32'(i)) begin failures++; $display("FAIL copy4_wr%0d got adr=%h dat=%h want adr=%h dat=%h", i, op_adr_q[2*i+1], op_dat_q[2*i+1], 32'h2000 + 32'(i * 4), 32'hc0de_0000 + 32'(i)); end
         end
      end
      checks++; if (lo_q.size() != 8) begin failures++; $display("FAIL copy4_gap_count got %0d want 8", lo_q.size()); end
      for (int i = 1; i < lo_q.size(); i++) begin
         checks++; if (lo_q[i] != 1 || hi_q[i-1] != 1) begin failures++; $display("FAIL copy4_gap%0d got gap=%0d access=%0d want 1 and 1", i, lo_q[i], hi_q[i-1]); end
      end
      reg_rd(32'hc, v);
      checks++; if (v !== 32'h4) begin failures++; $display("FAIL copy4_ctrl got %h want %h", v, 32'h4); end
      reg_rd(32'h8, v);
      checks++; if (v !== 32'h0) begin failures++; $display("FAIL copy4_count got %h want 0", v); end
      reg_rd(32'h0, v);
      checks++; if (v !== 32'h110) begin failures++; $display("FAIL copy4_src got %h want %h", v, 32'h110); end
      reg_rd(32'h4, v);
      checks++; if (v !== 32'h2010) begin failures++; $display("FAIL copy4_dst got %h want %h", v, 32'h2010); end
      reg_wr(32'hc, 32'h4);
   endtask

   task automatic test_count_zero();
      logic [31:0] v;
      clear_log();
      reg_wr(32'h8, 32'd0); reg_wr(32'hc, 32'h9);
      checks++; if (interrupt !== 1'b1) begin failures++; $display("FAIL zero_irq got %b want 1", interrupt); end
      repeat (4) @(posedge clk); #1;
      checks++; if (ack_count != 0 || hi_q.size() != 0 || hi_run != 0) begin failures++; $display("FAIL zero_no_cyc got acks=%0d runs=%0d want 0", ack_count, hi_q.size()); end
      reg_rd(32'hc, v);
      checks++; if (v !== 32'hc) begin failures++; $display("FAIL zero_ctrl got %h want %h", v, 32'hc); end
      reg_wr(32'hc, 32'h4);
      checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL zero_irq_clear got %b want 0", interrupt); end
      reg_rd(32'hc, v);
      checks++; if (v !== 32'h0) begin failures++; $display("FAIL zero_ctrl_clear got %h want 0", v); end
   endtask

   task automatic test_busy_write();
      logic [31:0] v;
      mem[32'h300] = 32'h1234_5678; mem[32'h304] = 32'h9abc_def0;
      wait_states = 3; clear_log();
      reg_wr(32'h0, 32'h300); reg_wr(32'h4, 32'h3000); reg_wr(32'h8, 32'd2); reg_wr(32'hc, 32'h1);
      reg_wr(32'h0, 32'hdead); reg_rd(32'h0, v);
      checks++; if (v !== 32'h300) begin failures++; $display("FAIL busy_src_hold got %h want %h", v, 32'h300); end
      reg_rd(32'hc, v);
      checks++; if (v !== 32'h2) begin failures++; $display("FAIL busy_ctrl got %h want %h", v, 32'h2); end
      wait_done("busy");
      reg_rd(32'h0, v);
      checks++; if (v !== 32'h308) begin failures++; $display("FAIL busy_src_final got %h want %h", v, 32'h308); end
      checks++; if (ack_count != 4) begin failures++; $display("FAIL busy_acks got %0d want 4", ack_count); end
      checks++; if (hi_q.size() < 1 || hi_q[0] != 4) begin failures++; $display("FAIL busy_wait_len got runs=%0d want first run 4", hi_q.size()); end
      checks++; if (mem[32'h3000] !== 32'h1234_5678 || mem[32'h3004] !== 32'h9abc_def0) begin failures++; $display("FAIL busy_data got %h %h want 12345678 9abcdef0", mem[32'h3000], mem[32'h3004]); end
      reg_wr(32'hc, 32'h4);
      wait_states = 0;
   endtask

   task automatic test_wrap();
      logic [31:0] v;
      clear_log();
      reg_wr(32'h0, 32'hffff_fffc); reg_wr(32'h4, 32'h4000); reg_wr(32'h8, 32'd2); reg_wr(32'hc, 32'h1);
      wait_done("wrap");
      checks++; if (op_adr_q.size() != 4 || op_adr_q[0] !== 32'hffff_fffc || op_adr_q[2] !== 32'h0) begin failures++; $display("FAIL wrap_rd_adr got n=%0d want ops=4 reads fffffffc then 00000000", op_adr_q.size()); end
      reg_rd(32'h0, v);
      checks++; if (v !== 32'h4) begin failures++; $display("FAIL wrap_src got %h want %h", v, 32'h4); end
      reg_wr(32'hc, 32'h4);
   endtask

   task automatic test_reset_mid();
      logic [31:0] v;
      int n = 0;
      wait_states = 2; clear_log();
      reg_wr(32'h0, 32'h500); reg_wr(32'h4, 32'h5000); reg_wr(32'h8, 32'd3); reg_wr(32'hc, 32'h9);
      do begin @(posedge clk); #1; n++; end while (!(mbus_cyc && mbus_we) && n < 100);
      checks++; if (!(mbus_cyc && mbus_we)) begin failures++; $display("FAIL rst_mid_no_wr got cyc=%b we=%b want 1 1", mbus_cyc, mbus_we); end
      #2 rst_i = 1'b0;
      #1;
      checks++; if (mbus_cyc !== 1'b0 || mbus_stb !== 1'b0) begin failures++; $display("FAIL rst_mid_drop got cyc=%b stb=%b want 0", mbus_cyc, mbus_stb); end
      @(posedge clk); #1 rst_i = 1'b1;
      wait_states = 0;
      checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL rst_mid_irq got %b want 0", interrupt); end
      for (int r = 0; r < 4; r++) begin
         reg_rd(32'(r * 4), v);
         checks++; if (v !== 32'd0) begin failures++; $display("FAIL rst_mid_reg%0d got %h want 0", r, v); end
      end
      mem[32'h600] = 32'h0bad_cafe; clear_log();
      reg_wr(32'h0, 32'h600); reg_wr(32'h4, 32'h6000); reg_wr(32'h8, 32'd1); reg_wr(32'hc, 32'h1);
      wait_done("rst_mid");
      reg_rd(32'hc, v);
      checks++; if (v !== 32'h4 || mem[32'h6000] !== 32'h0bad_cafe || ack_count != 2) begin failures++; $display("FAIL rst_mid_restart got ctrl=%h dat=%h acks=%0d want 00000004 0badcafe 2", v, mem[32'h6000], ack_count); end
      reg_wr(32'hc, 32'h4);
   endtask

`ifdef WB_DMA_TIMEOUT_EN
   task automatic test_timeout();
      logic [31:0] v;
      no_ack = 1'b1; clear_log();
      reg_wr(32'h0, 32'h700); reg_wr(32'h4, 32'h7000); reg_wr(32'h8, 32'd1); reg_wr(32'hc, 32'h9);
      wait_done("timeout");
      checks++; if (hi_q.size() != 1 || hi_q[0] != 16) begin failures++; $display("FAIL timeout_len got runs=%0d want one run of 16", hi_q.size()); end
      reg_rd(32'hc, v);
      checks++; if (v !== 32'h18 || interrupt !== 1'b1) begin failures++; $display("FAIL timeout_ctrl got %h irq=%b want 00000018 irq=1", v, interrupt); end
      reg_rd(32'h0, v);
      checks++; if (v !== 32'h700) begin failures++; $display("FAIL timeout_src got %h want %h", v, 32'h700); end
      reg_rd(32'h8, v);
      checks++; if (v !== 32'h1) begin failures++; $display("FAIL timeout_count got %h want 1", v); end
      no_ack = 1'b0;
      reg_wr(32'hc, 32'h18); reg_rd(32'hc, v);
      checks++; if (v !== 32'h8 || interrupt !== 1'b0) begin failures++; $display("FAIL timeout_clear got %h irq=%b want 00000008 irq=0", v, interrupt); end
      reg_wr(32'hc, 32'h0);
   endtask
`endif

   initial begin
      rst_i = 1'b0;
      bus_cyc = 1'b0; bus_stb = 1'b0; bus_we = 1'b0; bus_adr = '0; bus_dat_m = '0; bus_sel = '0;
      repeat (3) @(posedge clk);
      #1 rst_i = 1'b1;
      test_reset();
      test_regs();
      test_ack_hold();
      test_copy4();
      test_count_zero();
      test_busy_write();
      test_wrap();
      test_reset_mid();
`ifdef WB_DMA_TIMEOUT_EN
      test_timeout();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
